// File: rtl/adapter_pkg.sv
`default_nettype none
//==============================================================================
// adapter_pkg - shared types and constants for the AXIS<->BRAM adapter control.
// Rev 1.0
//==============================================================================
package adapter_pkg;

   localparam int LANES  = 36;
   localparam int ADDR_W = 9;
   localparam int CNT_W  = 6;
   localparam int CODE_W = 2 * LANES;

   localparam logic [1:0] LANE_HOLD  = 2'b00;
   localparam logic [1:0] LANE_LOAD  = 2'b01;
   localparam logic [1:0] LANE_CLEAR = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_PRIME = 3'd2,
      S_READ  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/axis_bram_adapter_cntl_if.sv
`default_nettype none
//==============================================================================
// axis_bram_adapter_cntl_if - control-path bundle between adapter FSM and datapath.
// Rev 1.0
//==============================================================================
interface axis_bram_adapter_cntl_if;
   import adapter_pkg::*;

   logic                 rw;
   logic [ADDR_W-1:0]    index_cntl;
   logic [ADDR_W-1:0]    size_cntl;
   logic                 stream_in_valid;
   logic                 stream_out_accep;
   logic [CODE_W-1:0]    from_axis_mux_cntl;
   logic [CNT_W-1:0]     to_axis_mux_cntl;
   logic                 bram_wen;
   logic                 bram_en;
   logic [ADDR_W-1:0]    bram_index;
   logic                 stream_out_tlast;
   logic [CNT_W-1:0]     cnt;
   logic                 ptr_end;
   logic                 ptr_start;
   logic                 ptr_end_by_one;

   modport master (
      input  rw, index_cntl, size_cntl, stream_in_valid, stream_out_accep,
      output from_axis_mux_cntl, to_axis_mux_cntl, bram_wen, bram_en, bram_index,
             stream_out_tlast, cnt, ptr_end, ptr_start, ptr_end_by_one
   );

   modport slave (
      output rw, index_cntl, size_cntl, stream_in_valid, stream_out_accep,
      input  from_axis_mux_cntl, to_axis_mux_cntl, bram_wen, bram_en, bram_index,
             stream_out_tlast, cnt, ptr_end, ptr_start, ptr_end_by_one
   );

endinterface
`default_nettype wire

// File: rtl/adapter_lane_dec.sv
`default_nettype none
//==============================================================================
// adapter_lane_dec - expands lane counter + load/clear into per-lane 2-bit codes.
// Rev 1.0
//==============================================================================
module adapter_lane_dec
   import adapter_pkg::*;
(
   input  logic [CNT_W-1:0]  cnt_i,
   input  logic              load_i,
   input  logic              clear_i,
   output logic [CODE_W-1:0] code_o
);

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign code_o[2*gi +: 2] = clear_i                          ? LANE_CLEAR :
                                 (load_i && cnt_i == CNT_W'(gi))  ? LANE_LOAD  :
                                                                    LANE_HOLD;
   end

endmodule
`default_nettype wire

// File: rtl/axis_bram_adapter_cntl.sv
`default_nettype none
//==============================================================================
// axis_bram_adapter_cntl - lane/word sequencing FSM for the AXIS<->BRAM adapter.
// Rev 1.0
//==============================================================================
module axis_bram_adapter_cntl
   import adapter_pkg::*;
(
   input  logic                          clk,
   input  logic                          rstn,
   axis_bram_adapter_cntl_if.master      bus
);

   state_t              state_q;
   logic [ADDR_W-1:0]   ptr_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                commit_q;
   logic                op_rw_q;

   logic                w_ptr_end;
   logic                w_last_lane;
   logic [ADDR_W-1:0]   w_ptr_inc;
   logic [CNT_W-1:0]    w_cnt_inc;
   logic                w_final;
   logic                w_load;
   logic                w_clear;
   logic                w_fetch;

   assign w_ptr_end   = (ptr_q == bus.size_cntl);
   assign w_last_lane = (cnt_q == CNT_W'(LANES - 1));
   assign w_ptr_inc   = ptr_q + 1'b1;
   assign w_cnt_inc   = w_last_lane ? '0 : cnt_q + 1'b1;

   // The last word's commit cycle closes the operation, so a beat there is dropped.
   assign w_final = (state_q == S_WRITE) && commit_q && w_ptr_end;
   assign w_load  = (state_q == S_WRITE) && bus.stream_in_valid && !w_final;
   assign w_clear = (state_q == S_IDLE);

   // Fetch the next word while the last lane leaves, so it lands as cnt wraps to 0.
   assign w_fetch = (state_q == S_READ) && w_last_lane && bus.stream_out_accep && !w_ptr_end;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         cnt_q    <= '0;
         commit_q <= 1'b0;
         op_rw_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               ptr_q    <= bus.index_cntl;
               cnt_q    <= '0;
               commit_q <= 1'b0;
               op_rw_q  <= bus.rw;
               state_q  <= bus.rw ? S_WRITE : S_PRIME;
            end
            S_WRITE: begin
               if (w_load) cnt_q <= w_cnt_inc;
               commit_q <= w_load && w_last_lane;
               if (commit_q) begin
                  if (w_ptr_end) state_q <= S_DONE;
                  else           ptr_q   <= w_ptr_inc;
               end
            end
            S_PRIME: begin
               commit_q <= 1'b0;
               state_q  <= S_READ;
            end
            S_READ: begin
               commit_q <= 1'b0;
               if (bus.stream_out_accep) begin
                  cnt_q <= w_cnt_inc;
                  if (w_last_lane) begin
                     if (w_ptr_end) state_q <= S_DONE;
                     else           ptr_q   <= w_ptr_inc;
                  end
               end
            end
            S_DONE: begin
               commit_q <= 1'b0;
               if (bus.rw != op_rw_q) state_q <= S_IDLE;
            end
            default: begin
               commit_q <= 1'b0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   adapter_lane_dec u_lane_dec (
      .cnt_i   (cnt_q),
      .load_i  (w_load),
      .clear_i (w_clear),
      .code_o  (bus.from_axis_mux_cntl)
   );

   assign bus.bram_wen         = (state_q == S_WRITE) && commit_q;
   assign bus.bram_en          = ((state_q == S_WRITE) && commit_q) || (state_q == S_PRIME) || w_fetch;
   assign bus.bram_index       = w_fetch ? w_ptr_inc : ptr_q;
   assign bus.stream_out_tlast = (state_q == S_READ) && w_ptr_end && w_last_lane;
   assign bus.to_axis_mux_cntl = cnt_q;
   assign bus.cnt              = cnt_q;
   assign bus.ptr_end          = w_ptr_end;
   assign bus.ptr_start        = (ptr_q == bus.index_cntl);
   assign bus.ptr_end_by_one   = (ptr_q == bus.size_cntl - 1'b1);

endmodule
`default_nettype wire

// File: tb/tb_axis_bram_adapter_cntl.sv
`default_nettype none
//==============================================================================
// tb_axis_bram_adapter_cntl - vector table, corner sequences and random ops
// against a word/beat level model of the adapter. Rev 1.0
//==============================================================================
module tb_axis_bram_adapter_cntl;
   import adapter_pkg::*;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   axis_bram_adapter_cntl_if bus ();

   axis_bram_adapter_cntl dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_code(input string name, input logic [CODE_W-1:0] act,
                           input logic [CODE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Lane code vector: LOAD at 'lane' (if >= 0), 'fill' everywhere else.
   function automatic logic [CODE_W-1:0] code_vec(input int lane, input logic [1:0] fill);
      logic [CODE_W-1:0] v;
      for (int j = 0; j < LANES; j++) v[2*j +: 2] = (j == lane) ? LANE_LOAD : fill;
      return v;
   endfunction

   function automatic bit handshake(input int mode, input int c);
      case (mode)
         1:       return ((c / 3) % 2) == 0;
         2:       return $urandom_range(0, 3) != 0;
         3:       return !(c == 20 || c == 21);
         default: return 1'b1;
      endcase
   endfunction

   // Runs one operation from the IDLE cycle (called at posedge+1 with the FSM in IDLE).
   // units = BRAM words read or written; end_c = cycle of last beat (read) / last write.
   task automatic run_op(input bit rw, input logic [8:0] idx, input logic [8:0] sz,
                         input int mode, input bit tail_valid, input int abort_at,
                         output int units, output int end_c);
      logic [8:0]  span;
      logic [8:0]  bq;
      logic [8:0]  wa;
      logic [15:0] asmr [LANES];
      int          wq [$];
      int          total_w, total_b, k, xfers, tail, budget, bad;
      bit          done, hs, send;
      span    = sz - idx;
      total_w = int'(span) + 1;
      total_b = total_w * LANES;
      k = 0; xfers = 0; tail = 0; done = 0; bq = 'x;
      budget  = total_b * 3 + 60;
      units   = 0;
      end_c   = -1;
      bus.rw = rw; bus.index_cntl = idx; bus.size_cntl = sz;
      for (int c = 0; c < budget && tail < 4; c++) begin
         hs = handshake(mode, c);
         send = 1'b0;
         if (rw) begin
            send = (c >= 1) && (k < total_b) && hs;
            bus.stream_in_valid  = send || (tail_valid && k >= total_b);
            bus.stream_out_accep = 1'($urandom_range(0, 1));
         end else begin
            bus.stream_in_valid  = 1'($urandom_range(0, 1));
            bus.stream_out_accep = hs;
         end
         @(negedge clk);
         if (c == 0) begin
            chk_code("idle_code", bus.from_axis_mux_cntl, code_vec(-1, LANE_CLEAR));
            chk("idle_en", bus.bram_en, 0);
            chk("idle_wen", bus.bram_wen, 0);
            chk("idle_tlast", bus.stream_out_tlast, 0);
         end else if (rw) begin
            chk_code("wr_code", bus.from_axis_mux_cntl,
                     send ? code_vec(k % LANES, LANE_HOLD) : code_vec(-1, LANE_HOLD));
            chk("wr_en_eq_wen", bus.bram_en, bus.bram_wen);
            chk("wr_tlast", bus.stream_out_tlast, 0);
            if (bus.bram_wen) begin
               chk("wr_extra", xfers < total_w, 1);
               chk("wr_addr", bus.bram_index, 9'(idx + 9'(xfers)));
               chk("wr_timing", c, (wq.size() > 0) ? wq.pop_front() : -1);
               bad = 0;
               for (int j = 0; j < LANES; j++)
                  if (asmr[j] !== 16'(xfers * LANES + j)) bad++;
               chk("wr_data_bad_lanes", bad, 0);
               xfers++;
               end_c = c;
            end
            if (send) begin
               if (k % LANES == LANES - 1) wq.push_back(c + 1);
            end
            done = (xfers == total_w);
         end else begin
            chk("rd_wen", bus.bram_wen, 0);
            if (c == 1) begin
               chk("prime_en", bus.bram_en, 1);
               chk("prime_ptr_start", bus.ptr_start, 1);
               chk("prime_ptr_end", bus.ptr_end, idx == sz);
            end
            if (bus.bram_en) begin
               chk("rd_extra", xfers < total_w, 1);
               chk("rd_addr", bus.bram_index, 9'(idx + 9'(xfers)));
               if (c >= 2) chk("rd_en_while_stalled", bus.stream_out_accep, 1);
               xfers++;
            end
            if (c >= 2 && k < total_b) begin
               wa = 9'(idx + 9'(k / LANES));
               chk("rd_lane", bus.to_axis_mux_cntl, k % LANES);
               chk("rd_cnt", bus.cnt, k % LANES);
               chk("rd_tlast", bus.stream_out_tlast, k == total_b - 1);
               chk("rd_ptr_end", bus.ptr_end, wa == sz);
               chk("rd_ptr_end_by_one", bus.ptr_end_by_one, wa == 9'(sz - 9'd1));
               if (bus.stream_out_accep) begin
                  chk("rd_word", bq, wa);
                  k++;
                  if (k == total_b) end_c = c;
               end
            end else if (c >= 2) begin
               chk("done_tlast", bus.stream_out_tlast, 0);
               chk("done_en", bus.bram_en, 0);
            end
            done = (k == total_b);
         end
         // Datapath model: apply this cycle's lane codes and BRAM read at the edge.
         if (rw) begin
            for (int j = 0; j < LANES; j++) begin
               if (bus.from_axis_mux_cntl[2*j +: 2] == LANE_LOAD)  asmr[j] = 16'(k);
               if (bus.from_axis_mux_cntl[2*j +: 2] == LANE_CLEAR) asmr[j] = 16'hFFFF;
            end
            if (send) k++;
         end else if (bus.bram_en && !bus.bram_wen) begin
            bq = bus.bram_index;
         end
         if (done) tail++;
         units = xfers;
         if (c == abort_at) return;
         @(posedge clk); #1;
      end
      chk("op_complete", done, 1);
   endtask

   task automatic reset_start(input bit rw, input logic [8:0] idx, input logic [8:0] sz);
      rstn = 1'b0;
      bus.rw = rw; bus.index_cntl = idx; bus.size_cntl = sz;
      bus.stream_in_valid = 1'b0; bus.stream_out_accep = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   // Leave DONE by flipping rw; the FSM is in IDLE on return.
   task automatic toggle_start(input bit rw, input logic [8:0] idx, input logic [8:0] sz);
      bus.rw = rw; bus.index_cntl = idx; bus.size_cntl = sz;
      @(negedge clk);
      chk("done_hold_en", bus.bram_en, 0);
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit         rw;
      logic [8:0] idx;
      logic [8:0] sz;
      int         exp_units;
      int         exp_end;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int  units, end_c, words;
      bit  rw, last_rw;
      logic [8:0] idx;

      tbl[0] = '{rw: 1'b0, idx: 9'd6,   sz: 9'd15,  exp_units: 10, exp_end: 361};
      tbl[1] = '{rw: 1'b1, idx: 9'd0,   sz: 9'd15,  exp_units: 16, exp_end: 577};
      tbl[2] = '{rw: 1'b0, idx: 9'd510, sz: 9'd1,   exp_units: 4,  exp_end: 145};
      tbl[3] = '{rw: 1'b1, idx: 9'd511, sz: 9'd511, exp_units: 1,  exp_end: 37};
      tbl[4] = '{rw: 1'b0, idx: 9'd100, sz: 9'd100, exp_units: 1,  exp_end: 37};
      tbl[5] = '{rw: 1'b1, idx: 9'd509, sz: 9'd2,   exp_units: 6,  exp_end: 217};

      bus.rw = 1'b0; bus.index_cntl = 9'd6; bus.size_cntl = 9'd15;
      bus.stream_in_valid = 1'b1; bus.stream_out_accep = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_code("rst_code", bus.from_axis_mux_cntl, code_vec(-1, LANE_CLEAR));
      chk("rst_en", bus.bram_en, 0);
      chk("rst_wen", bus.bram_wen, 0);
      chk("rst_tlast", bus.stream_out_tlast, 0);
      chk("rst_cnt", bus.cnt, 0);
      chk("rst_index", bus.bram_index, 0);

      // Table: back-to-back operations chained through DONE -> IDLE on rw change.
      for (int i = 0; i < 6; i++) begin
         if (i == 0) reset_start(tbl[i].rw, tbl[i].idx, tbl[i].sz);
         else        toggle_start(tbl[i].rw, tbl[i].idx, tbl[i].sz);
         run_op(tbl[i].rw, tbl[i].idx, tbl[i].sz, 0, 1'b0, -1, units, end_c);
         chk($sformatf("tbl%0d_units", i), units, tbl[i].exp_units);
         chk($sformatf("tbl%0d_end", i), end_c, tbl[i].exp_end);
      end

      // Read with accep toggling every 3 cycles.
      reset_start(1'b0, 9'd6, 9'd15);
      run_op(1'b0, 9'd6, 9'd15, 1, 1'b0, -1, units, end_c);
      chk("stall_rd_units", units, 10);

      // Write with valid dropped for two cycles mid-word: commits slip by 2.
      reset_start(1'b1, 9'd0, 9'd15);
      run_op(1'b1, 9'd0, 9'd15, 3, 1'b0, -1, units, end_c);
      chk("gap_wr_units", units, 16);
      chk("gap_wr_end", end_c, 579);

      // Valid held high through the final commit cycle and into DONE.
      reset_start(1'b1, 9'd3, 9'd4);
      run_op(1'b1, 9'd3, 9'd4, 0, 1'b1, -1, units, end_c);
      chk("tail_wr_units", units, 2);
      chk("tail_wr_end", end_c, 73);

      // Asynchronous reset in the middle of a read at cnt=17.
      reset_start(1'b0, 9'd6, 9'd15);
      run_op(1'b0, 9'd6, 9'd15, 0, 1'b0, 19, units, end_c);
      #2 rstn = 1'b0;
      #1;
      chk("arst_cnt", bus.cnt, 0);
      chk("arst_en", bus.bram_en, 0);
      chk("arst_wen", bus.bram_wen, 0);
      chk("arst_tlast", bus.stream_out_tlast, 0);
      chk("arst_index", bus.bram_index, 0);
      chk_code("arst_code", bus.from_axis_mux_cntl, code_vec(-1, LANE_CLEAR));
      reset_start(1'b0, 9'd40, 9'd41);
      run_op(1'b0, 9'd40, 9'd41, 0, 1'b0, -1, units, end_c);
      chk("arst_restart_units", units, 2);
      chk("arst_restart_end", end_c, 73);

      // Random operations with random handshakes.
      last_rw = 1'b0;
      for (int n = 0; n < 8; n++) begin
         rw    = 1'($urandom_range(0, 1));
         idx   = 9'($urandom);
         words = $urandom_range(1, 3);
         if (n > 0 && rw != last_rw)
            toggle_start(rw, idx, 9'(idx + 9'(words - 1)));
         else
            reset_start(rw, idx, 9'(idx + 9'(words - 1)));
         run_op(rw, idx, 9'(idx + 9'(words - 1)), 2, 1'($urandom_range(0, 1)), -1, units, end_c);
         chk($sformatf("rand%0d_units", n), units, words);
         last_rw = rw;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axis_bram_adapter_cntl.md
Name: axis_bram_adapter_cntl

Overview:
- Control path of the AXI-Stream ↔ BRAM adapter.
- In write mode it assembles LANES stream beats into one BRAM word through a lane mux and commits each word to BRAM. In read mode it fetches BRAM words and serialises them lane by lane onto the output stream.
- It generates mux selects, BRAM enable/write-enable/address and the stream TLAST. It carries no data; the datapath lives in the adapter top.

Parameters:
- LANES, 36, stream beats per BRAM word. The count register is 6 bits; from_axis_mux_cntl is 2*LANES bits.
- ADDR_W, 9, BRAM word address width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; one clock, reset is asynchronous and active-low.
- rw  in  1  mode: 1 = write (stream→BRAM), 0 = read (BRAM→stream).
- index_cntl  in  9  first word address.
- size_cntl  in  9  last word address, inclusive.
- stream_in_valid  in  1  input stream TVALID.
- stream_out_accep  in  1  output stream TREADY.
- from_axis_mux_cntl  out  72  per-lane 2-bit code for the input assembly register: 00 hold, 01 load beat, 10 clear, 11 reserved (treated as hold).
- to_axis_mux_cntl  out  6  lane select for the output mux; equals cnt.
- bram_wen  out  1  BRAM write enable.
- bram_en  out  1  BRAM enable.
- bram_index  out  9  BRAM address.
- stream_out_tlast  out  1  output TLAST.
- cnt  out  6  debug: lane counter.
- ptr_end  out  1  debug: ptr == size_cntl.
- ptr_start  out  1  debug: ptr == index_cntl.
- ptr_end_by_one  out  1  debug: ptr == size_cntl-1 (mod 512).

Behaviour:
- Registers: state, ptr (9 bits), cnt (6 bits), commit (1 bit). rstn low → state IDLE, ptr=0, cnt=0, commit=0 immediately, mid-operation included. All outputs then 0 except from_axis_mux_cntl (IDLE code) and the debug compares, which are combinational.
- States: IDLE, WRITE, PRIME, READ, DONE.
- IDLE: ptr<=index_cntl, cnt<=0, all lanes coded 10 (clear). Next state WRITE if rw=1, else PRIME. rw is sampled only in IDLE and DONE.
- WRITE: lane cnt coded 01 when stream_in_valid=1; all other lanes 00.
  - On valid: cnt<=cnt+1, or 0 when cnt==LANES-1.
  - commit<=valid && cnt==LANES-1.
  - bram_en=bram_wen=commit, bram_index=ptr.
  - On a commit cycle: if ptr_end go to DONE, else ptr<=ptr+1 (wraps 511→0).
  - A beat arriving on the final commit cycle is ignored.
  - No bubble between words.
- PRIME (1 cycle): bram_en=1, wen=0, bram_index=ptr. Next state READ. stream_out_accep is ignored. BRAM read latency is 1 cycle.
- READ: to_axis_mux_cntl=cnt. When accep=1: cnt<=cnt+1, or 0 when cnt==LANES-1.
  - When cnt==LANES-1 && accep && !ptr_end: bram_en=1, bram_index=ptr+1 (combinational), ptr<=ptr+1. The new word is valid exactly when cnt returns to 0, so there is no bubble.
  - Otherwise bram_en=0 and bram_index=ptr.
  - stream_out_tlast = READ && ptr_end && cnt==LANES-1.
  - A tlast beat accepted → DONE.
- DONE: bram_en=0, tlast=0. Stays in DONE until rw differs from its value when the operation started; then goes to IDLE.
- Address wrap: when index_cntl > size_cntl the sequence wraps through 511→0. All compares are 9-bit equality.
- accep=0 or valid=0 holds cnt and ptr and asserts no BRAM enable (except the pending commit).

Decomposition:
- Shared package adapter_pkg: state enum, lane code constants (HOLD/LOAD/CLEAR), LANES, ADDR_W.
- A sub-module is natural: adapter_lane_dec, which decodes cnt/load/clear into the 72-bit lane code vector. Everything else stays in one FSM module.

Test Plan:
- Read, index 6, size 15, accep=1 from the first READ cycle:
  - PRIME: en=1, addr 6.
  - to_axis_mux_cntl cycles 0..35 ten times, with reads at addr 7..15 on each cnt=35.
  - tlast on beat 360 only (ptr=15, cnt=35), then DONE with bram_en=0.
- Read with accep toggled 0/1 every 3 cycles → cnt and ptr frozen while accep=0; same addresses and tlast position as above; no bram_en while stalled.
- Write, index 0, size 15, valid=1 continuous:
  - lane codes 01 walk lanes 0..35.
  - bram_en=bram_wen=1 one cycle after each cnt=35, at addr 0..15 (16 commits, 36 cycles apart).
  - DONE after the addr-15 commit.
- Write with valid dropped for 2 cycles mid-word → cnt holds, lane codes all 00, commit delayed by 2 cycles; no extra write.
- Wrap: read, index 510, size 1 → fetch addresses 510, 511, 0, 1; ptr_end_by_one high while ptr=0; tlast at ptr=1, cnt=35.
- Reset mid-read (rstn low at cnt=17) → asynchronously IDLE, cnt=0, ptr=0, en/wen/tlast=0; after release, PRIME restarts at index_cntl.
